arst_sync_comb: RTL and testbench



---
 rtl/arst_pkg.sv | 12 +
 rtl/arst_sync_comb_if.sv | 12 +
 rtl/arst_sync_chain.sv | 27 ++
 rtl/arst_sync_comb.sv | 66 ++++++
 tb/tb_arst_sync_comb.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/arst_pkg.sv
// Shared constants and types for the reset-entry blocks.
package arst_pkg;

    // Default synchronizer depth and release stretch
    localparam int ARST_SYNC_STAGES_DEF = 2;
    localparam int ARST_STRETCH_DEF     = 0;

    // The stretch counter is 8 bits wide, so the stretch range is 0..255
    localparam int ARST_CNT_W = 8;
    typedef logic [ARST_CNT_W-1:0] stretch_cnt_t;

endpackage

// File: rtl/arst_sync_comb_if.sv
// Debug/status bundle for the reset-entry block: chain completion and stretch count.
interface arst_sync_comb_if;
    import arst_pkg::*;

    logic         sync_done;
    stretch_cnt_t stretch_cnt;

    // master: produced by the reset block; slave: observers such as monitors
    modport master (output sync_done, output stretch_cnt);
    modport slave  (input sync_done, input stretch_cnt);

endinterface

// File: rtl/arst_sync_chain.sv
// Async-clear / sync-release shift chain. A constant 1 enters stage 0 and
// walks one stage per rising clk edge; sync_done is the last stage.
module arst_sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    output logic sync_done
);

    // Keep the chain flops together and untouched so the tools treat them as
    // a metastability-resolving synchronizer.
    (* ASYNC_REG = "TRUE", dont_touch = "true" *)
    logic [SYNC_STAGES-1:0] chain;

    // Clear all stages the instant arst_n drops; otherwise shift a 1 in.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_done = chain[SYNC_STAGES-1];

endmodule

// File: rtl/arst_sync_comb.sv
// Reset-domain entry: ANDs the active-low reset sources, asserts the domain
// reset immediately and releases it synchronously after SYNC_STAGES edges plus
// STRETCH extra edges. The combined arst_n is the only reset of every flop.
module arst_sync_comb
    import arst_pkg::*;
#(
    parameter int N_SRC       = 1,
    parameter int SYNC_STAGES = ARST_SYNC_STAGES_DEF,
    parameter int STRETCH     = ARST_STRETCH_DEF
) (
    input  logic             clk,
    input  logic [N_SRC-1:0] rst_i,
    output logic             rst_o,
    arst_sync_comb_if.master dbg
);

    logic arst_n;
    logic sync_done;

    // Any low source requests reset; no other logic sits on the reset path.
    assign arst_n = &rst_i;

    arst_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_chain (
        .clk       (clk),
        .arst_n    (arst_n),
        .sync_done (sync_done)
    );

    generate
        if (STRETCH == 0) begin : g_no_stretch
            // The last chain flop already is the output register, so rst_o
            // can only rise on a clk edge and never straight from rst_i.
            assign rst_o           = sync_done;
            assign dbg.stretch_cnt = '0;
        end else begin : g_stretch
            localparam stretch_cnt_t TARGET = stretch_cnt_t'(STRETCH);

            stretch_cnt_t cnt;
            logic         rst_q;

            // Count edges after the chain releases, saturating at TARGET;
            // rst_q rises on the same edge the count reaches TARGET.
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    cnt   <= '0;
                    rst_q <= 1'b0;
                end else if (sync_done) begin
                    if (cnt != TARGET) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (cnt >= TARGET - 1'b1) begin
                        rst_q <= 1'b1;
                    end
                end
            end

            assign rst_o           = rst_q;
            assign dbg.stretch_cnt = cnt;
        end
    endgenerate

    assign dbg.sync_done = sync_done;

endmodule

// File: tb/tb_arst_sync_comb.sv
// Bench for arst_sync_comb: three instances (defaults, STRETCH=3, N_SRC=2)
// on a shared 6 ns clock. Expected rst_o rise times go into exp_q as
// {dut id, time}; one monitor per instance pops on every rising rst_o.
`timescale 1ns/1ps
module tb_arst_sync_comb;
    import arst_pkg::*;

    // ---------------- clock / reset block ----------------
    // Ticks every 3 ns; rising edges at 3, 9, 15, ... while clk_en = 1.
    logic clk    = 1'b0;
    bit   clk_en = 1'b1;
    initial forever begin
        #3;
        if (clk_en) clk = ~clk;
    end

    logic       rst_def_i;
    logic       rst_def_o;
    logic       rst_str_i;
    logic       rst_str_o;
    logic [1:0] rst_two_i;
    logic       rst_two_o;

    arst_sync_comb_if dbg_def ();
    arst_sync_comb_if dbg_str ();
    arst_sync_comb_if dbg_two ();

    arst_sync_comb #(.N_SRC(1), .SYNC_STAGES(2), .STRETCH(0)) u_def (
        .clk (clk), .rst_i (rst_def_i), .rst_o (rst_def_o), .dbg (dbg_def)
    );
    arst_sync_comb #(.N_SRC(1), .SYNC_STAGES(2), .STRETCH(3)) u_str (
        .clk (clk), .rst_i (rst_str_i), .rst_o (rst_str_o), .dbg (dbg_str)
    );
    arst_sync_comb #(.N_SRC(2), .SYNC_STAGES(2), .STRETCH(0)) u_two (
        .clk (clk), .rst_i (rst_two_i), .rst_o (rst_two_o), .dbg (dbg_two)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [39:0] exp_q[$];   // {id[7:0], rise_time[31:0]}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic push_rise(input logic [7:0] id, input logic [31:0] t);
        exp_q.push_back({id, t});
    endtask

    // On re-assertion, a pending rise still in the future is cancelled; one
    // already in the past means the DUT missed it.
    task automatic cancel_pending();
        logic [39:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_back();
            checks++;
            if (e[31:0] <= 32'($time)) begin
                errors++;
                $display("FAIL rise_missing: dut %0d t=%0t got no rise expected rise at %0d",
                         e[39:32], $time, e[31:0]);
            end
        end
    endtask

    task automatic on_rise(input logic [7:0] id);
        logic [39:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rise_unexpected: dut %0d got rise at t=%0t expected none", id, $time);
        end else begin
            e = exp_q.pop_front();
            if (e[39:32] != id || e[31:0] != 32'($time)) begin
                errors++;
                $display("FAIL rise_time: got dut %0d at t=%0t expected dut %0d at t=%0d",
                         id, $time, e[39:32], e[31:0]);
            end
        end
    endtask

    // ---------------- monitors ----------------
    always @(posedge rst_def_o) on_rise(8'd0);
    always @(posedge rst_str_o) on_rise(8'd1);
    always @(posedge rst_two_o) on_rise(8'd2);

    // ---------------- driver helpers ----------------
    task automatic wait_until(input real t);
        if (t > $realtime) #(t - $realtime);
    endtask

    // Rising edges sit at 3 mod 6; keep random stimulus off them.
    task automatic avoid_edge();
        if (longint'($time) % 6 == 3) #1;
    endtask

    // Rise time for a release at integer time r, for a two-stage chain.
    function automatic logic [31:0] next_rise(input longint r);
        longint m;
        m = r % 6;
        return 32'(r + (9 - m) % 6 + 6);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        longint t_rel;
        longint t_go;
        rst_def_i = 1'b1;
        rst_str_i = 1'b1;
        rst_two_i = 2'b11;
        #1;
        rst_def_i = 1'b0;
        rst_str_i = 1'b0;
        rst_two_i = 2'b00;

        // Reset state
        wait_until(2);
        check("reset_def_o", rst_def_o, 0);
        check("reset_str_o", rst_str_o, 0);
        check("reset_two_o", rst_two_o, 0);
        check("reset_str_cnt", dbg_str.stretch_cnt, 0);

        // Default release at 20: rise on 2nd edge (27)
        wait_until(20);
        rst_def_i = 1'b1;
        push_rise(8'd0, 27);
        wait_until(26);
        check("def_before_latency", rst_def_o, 0);
        wait_until(28);
        check("def_released", rst_def_o, 1);

        // Async assert at 48 (no edge), held low
        wait_until(48);
        rst_def_i = 1'b0;
        #0.001;
        check("def_async_assert", rst_def_o, 0);
        check("def_sync_cleared", dbg_def.sync_done, 0);
        wait_until(86);
        check("def_held_low", rst_def_o, 0);

        // STRETCH=3: release 116, abort at 126, re-release 146 -> rise 171
        wait_until(116);
        rst_str_i = 1'b1;
        push_rise(8'd1, 141);
        wait_until(125);
        check("str_sync_done", dbg_str.stretch_cnt == 0 && dbg_str.sync_done, 1);
        check("str_low_mid", rst_str_o, 0);
        wait_until(126);
        cancel_pending();
        rst_str_i = 1'b0;
        #0.001;
        check("str_reassert_o", rst_str_o, 0);
        check("str_reassert_sync", dbg_str.sync_done, 0);
        wait_until(146);
        rst_str_i = 1'b1;
        push_rise(8'd1, 171);
        wait_until(168);
        check("str_cnt_mid", dbg_str.stretch_cnt, 2);
        check("str_low_stretch", rst_str_o, 0);
        wait_until(172);
        check("str_released", rst_str_o, 1);
        wait_until(196);
        check("str_cnt_saturated", dbg_str.stretch_cnt, 3);
        check("str_drained", exp_q.size(), 0);

        // N_SRC=2: bit0 at 224, bit1 at 244 -> rise 255
        wait_until(224);
        rst_two_i = 2'b01;
        wait_until(243);
        check("two_one_src_low", rst_two_o, 0);
        check("two_sync_low", dbg_two.sync_done, 0);
        wait_until(244);
        rst_two_i = 2'b11;
        push_rise(8'd2, 255);
        wait_until(254);
        check("two_before_latency", rst_two_o, 0);
        wait_until(256);
        check("two_released", rst_two_o, 1);
        check("two_drained", exp_q.size(), 0);

        // Steady state on default instance
        wait_until(290);
        rst_def_i = 1'b1;
        push_rise(8'd0, 297);
        wait_until(300);
        check("def_rerelease", rst_def_o, 1);
        repeat (100) begin
            @(negedge clk);
            check("def_steady", rst_def_o, 1);
        end

        // Random assertions, glitches included
        for (int i = 0; i < 150; i++) begin
            #($urandom_range(1, 40));
            avoid_edge();
            cancel_pending();
            rst_def_i = 1'b0;
            #0.001;
            check("rand_assert", rst_def_o, 0);
            #0.999;
            #($urandom_range(0, 25));
            avoid_edge();
            rst_def_i = 1'b1;
            t_rel = longint'($time);
            push_rise(8'd0, next_rise(t_rel));
        end
        #30;
        check("rand_drained", exp_q.size(), 0);
        check("rand_final_high", rst_def_o, 1);

        // Clock stopped low: 1 ns glitch, then 2 edges after restart
        @(negedge clk);
        #1;
        clk_en = 1'b0;
        #10;
        rst_def_i = 1'b0;
        #0.001;
        check("stop_glitch_assert", rst_def_o, 0);
        #0.999;
        rst_def_i = 1'b1;
        #20;
        check("stop_held_low", rst_def_o, 0);
        check("stop_sync_low", dbg_def.sync_done, 0);
        t_go = longint'($time);
        clk_en = 1'b1;
        push_rise(8'd0, 32'(t_go + 3 - t_go % 3 + 6));
        #30;
        check("stop_drained", exp_q.size(), 0);
        check("stop_released", rst_def_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
